// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encoding and FSM state type for the multiply/divide unit.
package muldiv_pkg;

  // MTLO shares code 7 with MTHI; b[0]==1 selects LO.
  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MFHI  = 3'd5,
    OP_MFLO  = 3'd6,
    OP_MTHI  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_SIGN
  } state_t;

endpackage

// File: rtl/div_core.sv
// div_core: iterative restoring radix-2 divider on unsigned magnitudes.
// Ports: start loads dividend/divisor; XLEN steps follow, one per cycle;
// valid is high for the cycle after the last step, when quotient and
// remainder are final.
module div_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            valid
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] dvs;
  logic [XLEN:0]   partial;
  logic            fits;
  logic [XLEN-1:0] rem_next;

  // Quotient register doubles as the dividend shift register.
  assign partial  = {remainder, quotient[XLEN-1]};
  assign fits     = (partial >= {1'b0, dvs});
  assign rem_next = fits ? XLEN'(partial - {1'b0, dvs}) : partial[XLEN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient  <= '0;
      remainder <= '0;
      dvs       <= '0;
      cnt       <= '0;
      valid     <= 1'b0;
    end else if (start) begin
      quotient  <= dividend;
      remainder <= '0;
      dvs       <= divisor;
      cnt       <= CW'(XLEN);
      valid     <= 1'b0;
    end else begin
      valid <= (cnt == CW'(1));
      if (cnt != '0) begin
        cnt       <= cnt - 1'b1;
        quotient  <= {quotient[XLEN-2:0], fits};
        remainder <= rem_next;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Ports: start/op/a/b issue an operation; flush aborts it; busy, stall_req
// and done report progress; rd_data returns HI/LO for MFHI/MFLO.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic            flush,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] rd_data
);

  localparam int unsigned CW = (MUL_LAT > XLEN) ? $clog2(MUL_LAT + 1) : $clog2(XLEN + 1);

  state_t            state;
  logic [XLEN-1:0]   hi, lo, a_reg, b_reg;
  logic              sgn;
  logic [CW-1:0]     cnt;

  logic              op_signed, div_go;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN-1:0]   div_q, div_r, q_fix, r_fix;
  logic              div_valid;
  logic [2*XLEN-1:0] ext_a, ext_b, prod;

  assign busy      = (state != S_IDLE);
  assign stall_req = start & busy & (op != OP_NOP);

  assign op_signed = (op == OP_MULT) | (op == OP_DIV);
  assign div_go    = start & ~flush & (state == S_IDLE) & ((op == OP_DIV) | (op == OP_DIVU));
  assign a_mag     = (op_signed & a[XLEN-1]) ? -a : a;
  assign b_mag     = (op_signed & b[XLEN-1]) ? -b : b;

  div_core #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst_n     (rst),
    .start     (div_go),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (div_q),
    .remainder (div_r),
    .valid     (div_valid)
  );

  // Overflow (most-negative / -1) falls out of the magnitude path unchanged.
  assign q_fix = (sgn & (a_reg[XLEN-1] ^ b_reg[XLEN-1])) ? -div_q : div_q;
  assign r_fix = (sgn & a_reg[XLEN-1]) ? -div_r : div_r;

  assign ext_a = sgn ? {{XLEN{a_reg[XLEN-1]}}, a_reg} : {{XLEN{1'b0}}, a_reg};
  assign ext_b = sgn ? {{XLEN{b_reg[XLEN-1]}}, b_reg} : {{XLEN{1'b0}}, b_reg};
  assign prod  = ext_a * ext_b;

  always_comb begin
    rd_data = '0;
    if (op == OP_MFHI)      rd_data = hi;
    else if (op == OP_MFLO) rd_data = lo;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      hi    <= '0;
      lo    <= '0;
      a_reg <= '0;
      b_reg <= '0;
      sgn   <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              case (op)
                OP_MULT, OP_MULTU: begin
                  state <= S_MUL;
                  cnt   <= CW'(MUL_LAT - 1);
                  a_reg <= a;
                  b_reg <= b;
                  sgn   <= op_signed;
                end
                OP_DIV, OP_DIVU: begin
                  state <= S_DIV;
                  cnt   <= CW'(XLEN - 1);
                  a_reg <= a;
                  b_reg <= b;
                  sgn   <= op_signed;
                end
                OP_MTHI: begin
                  if (b[0]) lo <= a;
                  else      hi <= a;
                end
                default: ;
              endcase
            end
          end
          S_MUL: begin
            if (cnt == '0) begin
              {hi, lo} <= prod;
              state    <= S_IDLE;
              done     <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_DIV: begin
            if (cnt == '0) state <= S_SIGN;
            else           cnt   <= cnt - 1'b1;
          end
          S_SIGN: begin
            if (div_valid) begin
              if (b_reg == '0) begin
                lo <= '1;
                hi <= a_reg;
              end else begin
                lo <= q_fix;
                hi <= r_fix;
              end
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an
// arithmetic reference model of HI/LO.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned MUL_LAT = 4;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op    = OP_NOP;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        busy, stall_req, done;
  logic [31:0] rd_data;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  muldiv_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .flush     (flush),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: HI/LO as the architecture defines them, via plain arithmetic.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, q, r;
    longint unsigned ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    case (o)
      OP_MULT:  begin q = sx * sy; m_hi = q[63:32]; m_lo = q[31:0]; end
      OP_MULTU: begin p = ux * uy; m_hi = p[63:32]; m_lo = p[31:0]; end
      OP_DIV, OP_DIVU: begin
        if (y == 0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = x;
        end else if (o == OP_DIV) begin
          q = sx / sy; r = sx % sy;
          m_lo = q[31:0]; m_hi = r[31:0];
        end else begin
          m_lo = x / y; m_hi = x % y;
        end
      end
      OP_MTHI: if (y[0]) m_lo = x; else m_hi = x;
      default: ;
    endcase
  endtask

  // Called at a negedge with start low.
  task automatic read_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
    op = OP_MFHI; #1;
    check({tag, " hi"}, rd_data, eh);
    op = OP_MFLO; #1;
    check({tag, " lo"}, rd_data, el);
    op = OP_NOP;
  endtask

  // Called at the first negedge after acceptance; returns in the done cycle.
  task automatic wait_done(input string tag, input int exp_lat);
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " done"}, {31'b0, done}, 32'd1);
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    model(o, x, y);
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    if (o inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) begin
      wait_done(tag, (o == OP_MULT || o == OP_MULTU) ? int'(MUL_LAT) : int'(XLEN + 1));
      read_hilo({tag, " done-cycle"}, m_hi, m_lo);
      @(negedge clk);
      check({tag, " done width"}, {31'b0, done}, 32'd0);
    end else begin
      check({tag, " busy"}, {31'b0, busy}, 32'd0);
      check({tag, " no done"}, {31'b0, done}, 32'd0);
      read_hilo(tag, m_hi, m_lo);
    end
  endtask

  initial begin
    int n;
    logic [2:0] ro;
    logic [31:0] rx, ry;

    // Reset state
    #12;
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    start = 1'b1; op = OP_MFLO; #1;
    check("rst stall", {31'b0, stall_req}, 32'd0);
    start = 1'b0;
    read_hilo("rst", 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed arithmetic cases
    run("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3);
    read_hilo("mult const", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    read_hilo("multu const", 32'h0000_0002, 32'hFFFF_FFFA);
    run("div", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    read_hilo("div const", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divu", OP_DIVU, 32'd7, 32'd2);
    read_hilo("divu const", 32'd1, 32'd3);
    run("div0", OP_DIV, 32'd5, 32'd0);
    read_hilo("div0 const", 32'd5, 32'hFFFF_FFFF);
    run("divu0", OP_DIVU, 32'h8000_0001, 32'd0);
    run("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    read_hilo("divovf const", 32'd0, 32'h8000_0000);

    // MFLO while a DIV is in flight stalls until the done cycle
    start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
    model(OP_DIV, 32'd100, 32'd7);
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    @(negedge clk);
    start = 1'b1; op = OP_NOP; #1;
    check("nop no stall", {31'b0, stall_req}, 32'd0);
    @(negedge clk);
    op = OP_MFLO; #1;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      check("mflo stall", {31'b0, stall_req}, 32'd1);
      n++;
      @(negedge clk); #1;
    end
    check("mflo done", {31'b0, done}, 32'd1);
    check("mflo stall released", {31'b0, stall_req}, 32'd0);
    check("mflo quotient", rd_data, 32'd14);
    start = 1'b0; op = OP_NOP;
    @(negedge clk);

    // A MULT presented while busy is ignored
    start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd9;
    model(OP_DIVU, 32'd1000, 32'd9);
    @(negedge clk);
    op = OP_MULT; a = 32'd11; b = 32'd13;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    start = 1'b0; op = OP_NOP;
    check("ignored latency", 32'(n), 32'(XLEN + 1));
    read_hilo("ignored mult", m_hi, m_lo);
    @(negedge clk);
    check("ignored idle", {31'b0, busy}, 32'd0);

    // Flush mid-MULT
    run("mthi9", OP_MTHI, 32'd9, 32'd0);
    run("mtlo9", OP_MTHI, 32'd9, 32'd1);
    start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("flush no done", {31'b0, done}, 32'd0);
      @(negedge clk);
    end
    read_hilo("flush", 32'd9, 32'd9);

    // Flush in the same cycle as start
    start = 1'b1; flush = 1'b1; op = OP_DIV; a = 32'd50; b = 32'd5;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; op = OP_NOP;
    check("flush+start busy", {31'b0, busy}, 32'd0);
    read_hilo("flush+start", 32'd9, 32'd9);
    @(negedge clk);

    // MTHI with nothing in flight
    start = 1'b1; op = OP_MTHI; a = 32'h1234; b = 32'd0; #1;
    check("mthi stall", {31'b0, stall_req}, 32'd0);
    model(OP_MTHI, 32'h1234, 32'd0);
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    check("mthi busy", {31'b0, busy}, 32'd0);
    read_hilo("mthi", 32'h1234, 32'd9);
    @(negedge clk);

    // Back-to-back MULT: second accepted in the first's done cycle
    start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd6;
    @(negedge clk);
    a = 32'hFFFF_FFF9; b = 32'd8;
    model(OP_MULT, 32'hFFFF_FFF9, 32'd8);
    #1;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      check("b2b stall", {31'b0, stall_req}, 32'd1);
      n++;
      @(negedge clk); #1;
    end
    check("b2b first latency", 32'(n), 32'(MUL_LAT));
    check("b2b first done", {31'b0, done}, 32'd1);
    check("b2b stall released", {31'b0, stall_req}, 32'd0);
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    check("b2b second accepted", {31'b0, busy}, 32'd1);
    wait_done("b2b second", int'(MUL_LAT));
    read_hilo("b2b second", m_hi, m_lo);
    @(negedge clk);

    // Reset mid-DIV
    start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid-rst busy", {31'b0, busy}, 32'd0);
    check("mid-rst done", {31'b0, done}, 32'd0);
    start = 1'b1; op = OP_MFLO; #1;
    check("mid-rst stall", {31'b0, stall_req}, 32'd0);
    start = 1'b0;
    read_hilo("mid-rst", 32'd0, 32'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post-rst idle", {31'b0, busy}, 32'd0);

    // Random operations against the model
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 4))
        0:       ro = OP_MULT;
        1:       ro = OP_MULTU;
        2:       ro = OP_DIV;
        3:       ro = OP_DIVU;
        default: ro = OP_MTHI;
      endcase
      rx = $urandom;
      case ($urandom_range(0, 5))
        0:       ry = 32'd0;
        1:       ry = 32'($urandom_range(1, 20));
        2:       ry = -32'($urandom_range(1, 20));
        default: ry = $urandom;
      endcase
      run("random", ro, rx, ry);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
